sparse_stream: RTL and testbench

Streaming, parametrised successor to the scalar counter sparsifier. Sparse_stream accepts a stream of sketch counters in frames under a valid/ready handshake. Each counter at or below a threshold becomes zero; every other counter is rounded down to a multiple of a quantisation step. In dense mode it emits every counter. In compact mode it emits only non-zero results, each tagged with its in-frame index, and reports a per-frame non-zero count. It sits between the sketch readout and the compression/transmit path.

---
 rtl/sparse_pkg.sv | 22 ++
 rtl/sparse_quant.sv | 42 ++++
 rtl/sparse_stream.sv | 200 ++++++++++++++++++++
 tb/tb_sparse_stream.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sparse_pkg
// Description : Shared defaults and mode encoding for the sparse_stream
//               counter sparsifier and its helper blocks.
// Contents    : SPARSE_WIDTH, SPARSE_THRESHOLD, SPARSE_QUANT, SPARSE_IDX_W
//               default parameter values; MODE_DENSE / MODE_COMPACT encoding
//               of the per-frame output mode.
// Revision    : 1.0 - initial streaming release
// ============================================================================
package sparse_pkg;

  localparam int SPARSE_WIDTH     = 32;
  localparam int SPARSE_THRESHOLD = 20;
  localparam int SPARSE_QUANT     = 5;
  localparam int SPARSE_IDX_W     = 16;

  localparam logic MODE_DENSE   = 1'b0;
  localparam logic MODE_COMPACT = 1'b1;

endpackage : sparse_pkg
`default_nettype wire

// File: rtl/sparse_quant.sv
`default_nettype none
// ============================================================================
// Module      : sparse_quant
// Description : Combinational threshold-and-quantise of one counter value.
//               Values at or below THRESHOLD become 0; all others are rounded
//               down to a multiple of QUANT.
// Ports       : Value_i   [WIDTH-1:0]  counter value
//               Result_o  [WIDTH-1:0]  sparsified value
//               Nonzero_o              Result_o != 0
// Revision    : 1.0 - initial streaming release
// ============================================================================
module sparse_quant
  import sparse_pkg::*;
#(
  parameter int WIDTH     = SPARSE_WIDTH,
  parameter int THRESHOLD = SPARSE_THRESHOLD,
  parameter int QUANT     = SPARSE_QUANT
) (
  input  logic [WIDTH-1:0] Value_i,
  output logic [WIDTH-1:0] Result_o,
  output logic             Nonzero_o
);

  localparam logic [WIDTH-1:0] c_THRESH = WIDTH'(THRESHOLD);
  localparam logic [WIDTH-1:0] c_QUANT  = WIDTH'(QUANT);

  logic [WIDTH-1:0] w_kept;

  // v mod Q never exceeds v, so the subtraction cannot underflow.
  if (QUANT > 1) begin : g_quant
    assign w_kept = Value_i - (Value_i % c_QUANT);
  end else begin : g_no_quant
    assign w_kept = Value_i;
  end

  assign Result_o  = (Value_i <= c_THRESH) ? '0 : w_kept;
  // Zero test is on the quantised result: a value above the threshold but
  // below one step still counts as zero.
  assign Nonzero_o = |Result_o;

endmodule : sparse_quant
`default_nettype wire

// File: rtl/sparse_stream.sv
`default_nettype none
// ============================================================================
// Module      : sparse_stream
// Description : Two-stage streaming counter sparsifier. S1 registers the
//               input beat with its in-frame index and frame mode; S2 holds
//               the thresholded/quantised result. Dense mode emits every
//               beat, compact mode emits non-zero beats plus the frame's last
//               beat. A per-frame non-zero count is reported on a pulse.
// Ports       : Clk, Reset_n (async, active-low)
//               In_valid/In_ready/In_data/In_last/Compact  input stream
//               Out_valid/Out_ready/Out_data/Out_index/Out_last output stream
//               Nnz_valid/Nnz_count  frame summary pulse
//               Idx_overflow         sticky frame-length overflow flag
// Revision    : 1.0 - initial streaming release
// ============================================================================
module sparse_stream
  import sparse_pkg::*;
#(
  parameter int WIDTH     = SPARSE_WIDTH,
  parameter int THRESHOLD = SPARSE_THRESHOLD,
  parameter int QUANT     = SPARSE_QUANT,
  parameter int IDX_W     = SPARSE_IDX_W
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] In_data,
  input  logic             In_last,
  input  logic             Compact,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Out_data,
  output logic [IDX_W-1:0] Out_index,
  output logic             Out_last,
  output logic             Nnz_valid,
  output logic [IDX_W:0]   Nnz_count,
  output logic             Idx_overflow
);

  // Frame tracking
  logic             in_frame_q, in_frame_d;
  logic             mode_q, mode_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ovf_q, ovf_d;
  logic [IDX_W:0]   cnt_q, cnt_d;

  // Stage 1
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
  logic             s1_last_q, s1_last_d;
  logic             s1_mode_q, s1_mode_d;

  // Stage 2
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic [IDX_W-1:0] s2_idx_q, s2_idx_d;
  logic             s2_last_q, s2_last_d;

  // Frame summary
  logic             nnz_valid_q, nnz_valid_d;
  logic [IDX_W:0]   nnz_count_q, nnz_count_d;

  logic             w_en;
  logic             w_accept;
  logic             w_mode;
  logic [WIDTH-1:0] w_r;
  logic             w_nz;
  logic             w_emit;
  logic [IDX_W:0]   w_cnt_next;

  // One enable advances both stages; S1 may always refill when S2 moves.
  assign w_en     = !s2_valid_q || Out_ready;
  assign In_ready = w_en;
  assign w_accept = In_valid && w_en;

  // Mode is taken live on the first beat of a frame, from the latch after.
  assign w_mode = in_frame_q ? mode_q : Compact;

  sparse_quant #(
    .WIDTH    (WIDTH),
    .THRESHOLD(THRESHOLD),
    .QUANT    (QUANT)
  ) u_quant (
    .Value_i  (s1_data_q),
    .Result_o (w_r),
    .Nonzero_o(w_nz)
  );

  // The last beat always reaches S2 so every compact frame terminates.
  assign w_emit = s1_valid_q && ((s1_mode_q == MODE_DENSE) || w_nz || s1_last_q);

  assign w_cnt_next = (w_nz && (cnt_q != '1)) ? cnt_q + (IDX_W + 1)'(1) : cnt_q;

  always_comb begin
    in_frame_d  = in_frame_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_idx_d    = s1_idx_q;
    s1_last_d   = s1_last_q;
    s1_mode_d   = s1_mode_q;
    s2_valid_d  = s2_valid_q;
    s2_data_d   = s2_data_q;
    s2_idx_d    = s2_idx_q;
    s2_last_d   = s2_last_q;
    nnz_valid_d = 1'b0;
    nnz_count_d = nnz_count_q;

    if (w_accept) begin
      in_frame_d = !In_last;
      mode_d     = w_mode;
      idx_d      = In_last ? '0 : idx_q + IDX_W'(1);
      // Stepping past the all-ones index means the frame has more beats
      // than the index can name.
      if (!In_last && (&idx_q)) begin
        ovf_d = 1'b1;
      end
    end

    if (w_en) begin
      s1_valid_d = In_valid;
      if (In_valid) begin
        s1_data_d = In_data;
        s1_idx_d  = idx_q;
        s1_last_d = In_last;
        s1_mode_d = w_mode;
      end

      s2_valid_d = w_emit;
      if (w_emit) begin
        s2_data_d = w_r;
        s2_idx_d  = s1_idx_q;
        s2_last_d = s1_last_q;
      end

      if (s1_valid_q) begin
        if (s1_last_q) begin
          nnz_valid_d = 1'b1;
          nnz_count_d = w_cnt_next;
          cnt_d       = '0;
        end else begin
          cnt_d = w_cnt_next;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      in_frame_q  <= 1'b0;
      mode_q      <= MODE_DENSE;
      idx_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_idx_q    <= '0;
      s1_last_q   <= 1'b0;
      s1_mode_q   <= MODE_DENSE;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_idx_q    <= '0;
      s2_last_q   <= 1'b0;
      nnz_valid_q <= 1'b0;
      nnz_count_q <= '0;
    end else begin
      in_frame_q  <= in_frame_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_idx_q    <= s1_idx_d;
      s1_last_q   <= s1_last_d;
      s1_mode_q   <= s1_mode_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_idx_q    <= s2_idx_d;
      s2_last_q   <= s2_last_d;
      nnz_valid_q <= nnz_valid_d;
      nnz_count_q <= nnz_count_d;
    end
  end

  assign Out_valid    = s2_valid_q;
  assign Out_data     = s2_data_q;
  assign Out_index    = s2_idx_q;
  assign Out_last     = s2_last_q;
  assign Nnz_valid    = nnz_valid_q;
  assign Nnz_count    = nnz_count_q;
  assign Idx_overflow = ovf_q;

endmodule : sparse_stream
`default_nettype wire

// File: tb/tb_sparse_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_sparse_stream
// Description : Self-checking bench for sparse_stream. Expected output beats
//               and frame counts are queued as stimulus is driven; a monitor
//               collects observed beats, and each scenario task compares them.
//               A second instance runs with THRESHOLD=1, QUANT=5.
// Revision    : 1.0 - initial streaming release
// ============================================================================
module tb_sparse_stream;

  localparam int W  = 32;
  localparam int IW = 16;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [IW-1:0] i;
    logic          l;
  } beat_t;

  logic          Clk       = 1'b0;
  logic          Reset_n   = 1'b0;
  logic          In_valid  = 1'b0;
  logic          In_last   = 1'b0;
  logic          Compact   = 1'b0;
  logic          Out_ready = 1'b1;
  logic          sel2      = 1'b0;
  logic [W-1:0]  In_data   = '0;

  logic          v1, v2;
  logic          rdy1, ov1, ol1, nv1, of1;
  logic          rdy2, ov2, ol2, nv2, of2;
  logic [W-1:0]  od1, od2;
  logic [IW-1:0] oi1, oi2;
  logic [IW:0]   nc1, nc2;

  logic          m_rdy, m_ov, m_ol, m_nv;
  logic [W-1:0]  m_od;
  logic [IW-1:0] m_oi;
  logic [IW:0]   m_nc;

  beat_t       exp_q[$];
  beat_t       obs_q[$];
  int          obs_cyc[$];
  int          acc_cyc[$];
  logic [IW:0] nnz_exp[$];
  logic [IW:0] nnz_obs[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rdy_low_seen = 1'b0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  assign v1 = In_valid && !sel2;
  assign v2 = In_valid && sel2;

  sparse_stream u_dut1 (
    .Clk(Clk), .Reset_n(Reset_n),
    .In_valid(v1), .In_ready(rdy1), .In_data(In_data), .In_last(In_last), .Compact(Compact),
    .Out_valid(ov1), .Out_ready(Out_ready), .Out_data(od1), .Out_index(oi1), .Out_last(ol1),
    .Nnz_valid(nv1), .Nnz_count(nc1), .Idx_overflow(of1)
  );

  sparse_stream #(.THRESHOLD(1), .QUANT(5)) u_dut2 (
    .Clk(Clk), .Reset_n(Reset_n),
    .In_valid(v2), .In_ready(rdy2), .In_data(In_data), .In_last(In_last), .Compact(Compact),
    .Out_valid(ov2), .Out_ready(Out_ready), .Out_data(od2), .Out_index(oi2), .Out_last(ol2),
    .Nnz_valid(nv2), .Nnz_count(nc2), .Idx_overflow(of2)
  );

  assign m_rdy = sel2 ? rdy2 : rdy1;
  assign m_ov  = sel2 ? ov2  : ov1;
  assign m_od  = sel2 ? od2  : od1;
  assign m_oi  = sel2 ? oi2  : oi1;
  assign m_ol  = sel2 ? ol2  : ol1;
  assign m_nv  = sel2 ? nv2  : nv1;
  assign m_nc  = sel2 ? nc2  : nc1;

  // Inputs change 1 time unit after the rising edge; everything is sampled
  // on the falling edge, i.e. just before the edge that performs transfers.
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (m_ov && Out_ready) begin
        obs_q.push_back(beat_t'({m_od, m_oi, m_ol}));
        obs_cyc.push_back(cyc);
      end
      if (m_nv) nnz_obs.push_back(m_nc);
      if (In_valid && m_rdy) acc_cyc.push_back(cyc);
      if (In_valid && !m_rdy && m_ov) rdy_low_seen = 1'b1;
    end
  end

  function automatic beat_t mk(input logic [W-1:0] d, input int i, input logic l);
    beat_t b;
    b.d = d;
    b.i = IW'(i);
    b.l = l;
    return b;
  endfunction

  function automatic logic [W-1:0] model_r(input logic [W-1:0] v);
    if (v <= 20) return '0;
    return v - (v % 5);
  endfunction

  task automatic clear_all();
    exp_q.delete(); obs_q.delete(); obs_cyc.delete(); acc_cyc.delete();
    nnz_exp.delete(); nnz_obs.delete();
  endtask

  task automatic send_beat(input logic [W-1:0] d, input logic l, input logic c);
    int n;
    n = 0;
    In_valid = 1'b1;
    In_data  = d;
    In_last  = l;
    Compact  = c;
    @(negedge Clk);
    while (!m_rdy && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (!m_rdy) begin
      total++; bad++;
      $display("FAIL send_timeout: In_ready=%0b after %0d cycles, want 1", m_rdy, n);
    end
    @(posedge Clk); #1;
    In_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int k;
    k = 0;
    while (obs_q.size() < n && k < 200) begin
      @(negedge Clk);
      k++;
    end
    repeat (4) @(negedge Clk);
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    total++; if (ov1 !== 1'b0)  begin bad++; $display("FAIL rst_out_valid: got %0b want 0", ov1); end
    total++; if (od1 !== '0)    begin bad++; $display("FAIL rst_out_data: got %0h want 0", od1); end
    total++; if (oi1 !== '0)    begin bad++; $display("FAIL rst_out_index: got %0d want 0", oi1); end
    total++; if (ol1 !== 1'b0)  begin bad++; $display("FAIL rst_out_last: got %0b want 0", ol1); end
    total++; if (nv1 !== 1'b0)  begin bad++; $display("FAIL rst_nnz_valid: got %0b want 0", nv1); end
    total++; if (nc1 !== '0)    begin bad++; $display("FAIL rst_nnz_count: got %0d want 0", nc1); end
    total++; if (of1 !== 1'b0)  begin bad++; $display("FAIL rst_idx_overflow: got %0b want 0", of1); end
    total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %0b want 1", rdy1); end
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_dense();
    beat_t e, o;
    logic [IW:0] ne, no;
    int lat;
    clear_all();
    exp_q.push_back(mk(32'd0,   0, 1'b0));
    exp_q.push_back(mk(32'd20,  1, 1'b0));
    exp_q.push_back(mk(32'd35,  2, 1'b0));
    exp_q.push_back(mk(32'd100, 3, 1'b1));
    nnz_exp.push_back(17'd3);
    send_beat(32'd20, 1'b0, 1'b0);
    send_beat(32'd21, 1'b0, 1'b0);
    send_beat(32'd37, 1'b0, 1'b0);
    send_beat(32'd100, 1'b1, 1'b0);
    wait_out(4);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL dense_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    lat = (obs_cyc.size() > 0 && acc_cyc.size() > 0) ? obs_cyc[0] - acc_cyc[0] : -1;
    total++;
    if (lat != 2) begin bad++; $display("FAIL dense_latency: got %0d cycles want 2", lat); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL dense_beat: got none want d=%0h i=%0d l=%0b", e.d, e.i, e.l);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          bad++; $display("FAIL dense_beat: got d=%0h i=%0d l=%0b want d=%0h i=%0d l=%0b",
                          o.d, o.i, o.l, e.d, e.i, e.l);
        end
      end
    end
    while (nnz_exp.size() > 0) begin
      ne = nnz_exp.pop_front(); total++;
      no = (nnz_obs.size() > 0) ? nnz_obs.pop_front() : 'x;
      if (no !== ne) begin bad++; $display("FAIL dense_nnz: got %0d want %0d", no, ne); end
    end
  endtask

  task automatic test_compact();
    beat_t e, o;
    logic [IW:0] ne, no;
    clear_all();
    exp_q.push_back(mk(32'd25, 1, 1'b0));
    exp_q.push_back(mk(32'd40, 3, 1'b1));
    nnz_exp.push_back(17'd2);
    exp_q.push_back(mk(32'd0, 2, 1'b1));
    nnz_exp.push_back(17'd0);
    // Compact drops to 0 after the first beat; the frame must stay compact.
    send_beat(32'd0,  1'b0, 1'b1);
    send_beat(32'd25, 1'b0, 1'b0);
    send_beat(32'd3,  1'b0, 1'b0);
    send_beat(32'd44, 1'b1, 1'b0);
    send_beat(32'd5,  1'b0, 1'b1);
    send_beat(32'd20, 1'b0, 1'b1);
    send_beat(32'd10, 1'b1, 1'b1);
    wait_out(3);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL compact_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL compact_beat: got none want d=%0h i=%0d l=%0b", e.d, e.i, e.l);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          bad++; $display("FAIL compact_beat: got d=%0h i=%0d l=%0b want d=%0h i=%0d l=%0b",
                          o.d, o.i, o.l, e.d, e.i, e.l);
        end
      end
    end
    while (nnz_exp.size() > 0) begin
      ne = nnz_exp.pop_front(); total++;
      no = (nnz_obs.size() > 0) ? nnz_obs.pop_front() : 'x;
      if (no !== ne) begin bad++; $display("FAIL compact_nnz: got %0d want %0d", no, ne); end
    end
  endtask

  task automatic test_threshold1();
    beat_t e, o;
    logic [IW:0] ne, no;
    clear_all();
    sel2 = 1'b1;
    exp_q.push_back(mk(32'd5, 1, 1'b1));
    nnz_exp.push_back(17'd1);
    send_beat(32'd3, 1'b0, 1'b1);
    send_beat(32'd7, 1'b1, 1'b1);
    wait_out(1);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL thr1_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL thr1_beat: got none want d=%0h i=%0d l=%0b", e.d, e.i, e.l);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          bad++; $display("FAIL thr1_beat: got d=%0h i=%0d l=%0b want d=%0h i=%0d l=%0b",
                          o.d, o.i, o.l, e.d, e.i, e.l);
        end
      end
    end
    while (nnz_exp.size() > 0) begin
      ne = nnz_exp.pop_front(); total++;
      no = (nnz_obs.size() > 0) ? nnz_obs.pop_front() : 'x;
      if (no !== ne) begin bad++; $display("FAIL thr1_nnz: got %0d want %0d", no, ne); end
    end
    sel2 = 1'b0;
  endtask

  task automatic test_max_value();
    beat_t e, o;
    logic [IW:0] ne, no;
    clear_all();
    exp_q.push_back(mk(32'hFFFF_FFFF, 0, 1'b1));
    nnz_exp.push_back(17'd1);
    send_beat(32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_out(1);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL max_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL max_beat: got none want d=%0h i=%0d l=%0b", e.d, e.i, e.l);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          bad++; $display("FAIL max_beat: got d=%0h i=%0d l=%0b want d=%0h i=%0d l=%0b",
                          o.d, o.i, o.l, e.d, e.i, e.l);
        end
      end
    end
    while (nnz_exp.size() > 0) begin
      ne = nnz_exp.pop_front(); total++;
      no = (nnz_obs.size() > 0) ? nnz_obs.pop_front() : 'x;
      if (no !== ne) begin bad++; $display("FAIL max_nnz: got %0d want %0d", no, ne); end
    end
  endtask

  task automatic test_back_to_back();
    beat_t e, o;
    logic [IW:0] ne, no;
    clear_all();
    exp_q.push_back(mk(32'd30, 0, 1'b0));
    exp_q.push_back(mk(32'd30, 1, 1'b1));
    exp_q.push_back(mk(32'd40, 0, 1'b1));
    nnz_exp.push_back(17'd2);
    nnz_exp.push_back(17'd1);
    send_beat(32'd30, 1'b0, 1'b0);
    send_beat(32'd31, 1'b1, 1'b0);
    send_beat(32'd40, 1'b1, 1'b0);
    wait_out(3);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL b2b_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL b2b_beat: got none want d=%0h i=%0d l=%0b", e.d, e.i, e.l);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          bad++; $display("FAIL b2b_beat: got d=%0h i=%0d l=%0b want d=%0h i=%0d l=%0b",
                          o.d, o.i, o.l, e.d, e.i, e.l);
        end
      end
    end
    while (nnz_exp.size() > 0) begin
      ne = nnz_exp.pop_front(); total++;
      no = (nnz_obs.size() > 0) ? nnz_obs.pop_front() : 'x;
      if (no !== ne) begin bad++; $display("FAIL b2b_nnz: got %0d want %0d", no, ne); end
    end
  endtask

  task automatic test_backpressure();
    beat_t e, o;
    logic [IW:0] ne, no;
    int nz;
    clear_all();
    rdy_low_seen = 1'b0;
    nz = 0;
    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] v;
      v = W'(15 + i * 6);
      exp_q.push_back(mk(model_r(v), i, i == 9));
      if (model_r(v) != 0) nz++;
    end
    nnz_exp.push_back((IW + 1)'(nz));
    fork
      begin
        for (int i = 0; i < 10; i++) send_beat(W'(15 + i * 6), i == 9, 1'b0);
      end
      begin
        repeat (3) @(posedge Clk);
        #1 Out_ready = 1'b0;
        repeat (5) @(posedge Clk);
        #1 Out_ready = 1'b1;
      end
    join
    wait_out(10);
    total++;
    if (rdy_low_seen !== 1'b1) begin
      bad++; $display("FAIL bp_in_ready_low: got %0b want 1", rdy_low_seen);
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL bp_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL bp_beat: got none want d=%0h i=%0d l=%0b", e.d, e.i, e.l);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          bad++; $display("FAIL bp_beat: got d=%0h i=%0d l=%0b want d=%0h i=%0d l=%0b",
                          o.d, o.i, o.l, e.d, e.i, e.l);
        end
      end
    end
    while (nnz_exp.size() > 0) begin
      ne = nnz_exp.pop_front(); total++;
      no = (nnz_obs.size() > 0) ? nnz_obs.pop_front() : 'x;
      if (no !== ne) begin bad++; $display("FAIL bp_nnz: got %0d want %0d", no, ne); end
    end
  endtask

  task automatic test_reset_midframe();
    beat_t e, o;
    logic [IW:0] ne, no;
    clear_all();
    // Fill both stages of a partial frame and hold them with backpressure.
    Out_ready = 1'b0;
    send_beat(32'd60, 1'b0, 1'b0);
    send_beat(32'd70, 1'b0, 1'b0);
    Reset_n = 1'b0;
    @(negedge Clk);
    total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid: got %0b want 0", ov1); end
    total++; if (od1 !== '0)   begin bad++; $display("FAIL mid_rst_out_data: got %0h want 0", od1); end
    total++; if (oi1 !== '0)   begin bad++; $display("FAIL mid_rst_out_index: got %0d want 0", oi1); end
    total++; if (nc1 !== '0)   begin bad++; $display("FAIL mid_rst_nnz_count: got %0d want 0", nc1); end
    total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL mid_rst_in_ready: got %0b want 1", rdy1); end
    @(posedge Clk); #1;
    Reset_n   = 1'b1;
    Out_ready = 1'b1;
    clear_all();
    exp_q.push_back(mk(32'd50, 0, 1'b0));
    exp_q.push_back(mk(32'd0,  1, 1'b1));
    nnz_exp.push_back(17'd1);
    send_beat(32'd50, 1'b0, 1'b0);
    send_beat(32'd4,  1'b1, 1'b0);
    wait_out(2);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL mid_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL mid_beat: got none want d=%0h i=%0d l=%0b", e.d, e.i, e.l);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          bad++; $display("FAIL mid_beat: got d=%0h i=%0d l=%0b want d=%0h i=%0d l=%0b",
                          o.d, o.i, o.l, e.d, e.i, e.l);
        end
      end
    end
    while (nnz_exp.size() > 0) begin
      ne = nnz_exp.pop_front(); total++;
      no = (nnz_obs.size() > 0) ? nnz_obs.pop_front() : 'x;
      if (no !== ne) begin bad++; $display("FAIL mid_nnz: got %0d want %0d", no, ne); end
    end
    total++;
    if (of1 !== 1'b0) begin bad++; $display("FAIL idx_overflow: got %0b want 0", of1); end
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    test_reset();
    test_dense();
    test_compact();
    test_threshold1();
    test_max_value();
    test_back_to_back();
    test_backpressure();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_sparse_stream
`default_nettype wire
